// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage and its surroundings: pipeline controls,
// the two synchronous-read instruction memories, and the instruction handed to decode.
interface fetch_if #(
  parameter int BIOS_AW = 12,
  parameter int IMEM_AW = 14
);
  // No valid/ready handshake here: fetch delivers one word per cycle. stall holds the PC
  // and replays the current word; pc_sel chooses PC+4 / redirect / hold for the next fetch.
  logic               stall;
  logic [1:0]         pc_sel;
  logic [31:0]        br_target;
  logic [31:0]        bios_dout;
  logic [31:0]        imem_dout;
  logic [BIOS_AW-1:0] bios_addr;
  logic               bios_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_en;
  logic [31:0]        inst;
  logic [31:0]        inst_pc;
  logic               inst_valid;
  logic               fetch_fault;

  modport master (
    input  stall, pc_sel, br_target, bios_dout, imem_dout,
    output bios_addr, bios_en, imem_addr, imem_en,
           inst, inst_pc, inst_valid, fetch_fault
  );

  modport slave (
    output stall, pc_sel, br_target, bios_dout, imem_dout,
    input  bios_addr, bios_en, imem_addr, imem_en,
           inst, inst_pc, inst_valid, fetch_fault
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch half of IF/D: owns the PC, drives BIOS/IMEM read ports from the
// next PC and presents the returned word (or a NOP bubble) with its PC to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    SRC_BIOS = 2'd0,
    SRC_IMEM = 2'd1,
    SRC_NONE = 2'd2
  } src_t;

  function automatic src_t region(input logic [31:0] pc);
    case (pc[31:28])
      4'h4:    region = SRC_BIOS;
      4'h1:    region = SRC_IMEM;
      default: region = SRC_NONE;
    endcase
  endfunction

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  src_t        src_q;
  src_t        src_next;
  logic        valid_q;
  logic        fault_q;
  logic        hold;
  logic        redirect;
  logic        kill;
  logic [31:0] br_aligned;

  assign hold       = bus.stall | (bus.pc_sel == 2'd2);
  assign redirect   = (bus.pc_sel == 2'd1) & ~bus.stall;
  assign br_aligned = bus.br_target & ~32'd3;

  // The startup cycle re-fetches RESET_PC so the first word is presented with
  // valid_q high on the cycle after the bubble.
  always_comb begin
    pc_next = pc_q + 32'd4;
    if (rst)           pc_next = RESET_PC;
    else if (hold)     pc_next = pc_q;
    else if (!valid_q) pc_next = pc_q;
    else if (redirect) pc_next = br_aligned;
  end

  assign src_next = region(pc_next);

  // With enable low the RAMs keep their last output, which is exactly the replay word.
  assign bus.bios_addr = pc_next[BIOS_AW+1:2];
  assign bus.imem_addr = pc_next[IMEM_AW+1:2];
  assign bus.bios_en   = (src_next == SRC_BIOS) & (rst | ~hold);
  assign bus.imem_en   = (src_next == SRC_IMEM) & (rst | ~hold);

  // Redirect kills combinationally so the wrong-path word never reaches EX.
  assign kill           = ~valid_q | redirect | (src_q == SRC_NONE);
  assign bus.inst       = kill ? NOP : ((src_q == SRC_BIOS) ? bus.bios_dout : bus.imem_dout);
  assign bus.inst_pc    = pc_q;
  assign bus.inst_valid = ~kill;
  assign bus.fetch_fault = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      src_q   <= SRC_BIOS;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_next;
      src_q   <= src_next;
      valid_q <= 1'b1;
      if (valid_q && (src_q == SRC_NONE)) fault_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a PC-level reference model predicts each cycle's
// outputs into a queue; a monitor pops and compares them against the DUT.
module tb_fetch_stage;

  localparam int          BIOS_AW  = 12;
  localparam int          IMEM_AW  = 14;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          W        = 32 + 32 + 4 + BIOS_AW + IMEM_AW;

  logic clk;
  logic rst;

  fetch_if #(.BIOS_AW(BIOS_AW), .IMEM_AW(IMEM_AW)) bus ();

  fetch_stage #(
    .RESET_PC(RESET_PC), .BIOS_AW(BIOS_AW), .IMEM_AW(IMEM_AW), .NOP(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory environment ----------------
  logic [31:0] bios_mem [0:(1<<BIOS_AW)-1];
  logic [31:0] imem_mem [0:(1<<IMEM_AW)-1];
  logic [31:0] bios_rd;
  logic [31:0] imem_rd;

  always @(posedge clk) begin
    if (bus.bios_en) bios_rd <= bios_mem[bus.bios_addr];
    if (bus.imem_en) imem_rd <= imem_mem[bus.imem_addr];
  end
  assign bus.bios_dout = bios_rd;
  assign bus.imem_dout = imem_rd;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_fault;

  function automatic bit in_bios(input logic [31:0] pc);
    return pc[31:28] == 4'h4;
  endfunction

  function automatic bit in_imem(input logic [31:0] pc);
    return pc[31:28] == 4'h1;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [BIOS_AW-1:0] ba;
    logic [IMEM_AW-1:0] ia;
    ba = pc[BIOS_AW+1:2];
    ia = pc[IMEM_AW+1:2];
    if (in_bios(pc)) return bios_mem[ba];
    if (in_imem(pc)) return imem_mem[ia];
    return NOP;
  endfunction

  // One cycle of the model: what decode should see now, and where the PC goes next.
  task automatic model_step(input bit r, input bit st, input logic [1:0] sel,
                            input logic [31:0] tgt);
    bit           hold, redir, live, be, ie;
    logic [31:0]  npc, e_inst;
    logic [BIOS_AW-1:0] e_ba;
    logic [IMEM_AW-1:0] e_ia;
    if (r) begin
      m_pc      = RESET_PC;
      m_started = 1'b0;
      m_fault   = 1'b0;
      return;
    end
    hold  = st || (sel == 2'd2);
    redir = (sel == 2'd1) && !st;
    live  = m_started && !redir && (in_bios(m_pc) || in_imem(m_pc));
    e_inst = live ? word_at(m_pc) : NOP;
    if (hold || !m_started) npc = m_pc;
    else if (redir)         npc = {tgt[31:2], 2'b00};
    else                    npc = m_pc + 32'd4;
    be   = in_bios(npc) && !hold;
    ie   = in_imem(npc) && !hold;
    e_ba = be ? npc[BIOS_AW+1:2] : '0;
    e_ia = ie ? npc[IMEM_AW+1:2] : '0;
    exp_q.push_back({e_inst, m_pc, live, m_fault, be, ie, e_ba, e_ia});
    if (m_started && !(in_bios(m_pc) || in_imem(m_pc))) m_fault = 1'b1;
    m_started = 1'b1;
    m_pc      = npc;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit st, input logic [1:0] sel,
                      input logic [31:0] tgt);
    @(negedge clk);
    rst           = r;
    bus.stall     = st;
    bus.pc_sel    = sel;
    bus.br_target = tgt;
    cyc++;
    model_step(r, st, sel, tgt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL cyc=%0d %s got=%h exp=%h", cyc, name, got, want);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [BIOS_AW-1:0] a_ba;
    logic [IMEM_AW-1:0] a_ia;
    #2;
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      a_ba = bus.bios_en ? bus.bios_addr : '0;
      a_ia = bus.imem_en ? bus.imem_addr : '0;
      check("inst",        bus.inst,    e[W-1 -: 32]);
      check("inst_pc",     bus.inst_pc, e[W-33 -: 32]);
      check("inst_valid",  {31'd0, bus.inst_valid},  {31'd0, e[W-65]});
      check("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, e[W-66]});
      check("bios_en",     {31'd0, bus.bios_en},     {31'd0, e[W-67]});
      check("imem_en",     {31'd0, bus.imem_en},     {31'd0, e[W-68]});
      check("bios_addr",   {{(32-BIOS_AW){1'b0}}, a_ba}, {{(32-BIOS_AW){1'b0}}, e[IMEM_AW +: BIOS_AW]});
      check("imem_addr",   {{(32-IMEM_AW){1'b0}}, a_ia}, {{(32-IMEM_AW){1'b0}}, e[0 +: IMEM_AW]});
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_target();
    int k;
    k = $urandom_range(0, 99);
    if (k < 45) return {4'h4, 14'd0, $urandom_range(0, (1<<BIOS_AW)-1) , 2'($urandom_range(0, 3))} ;
    if (k < 93) return {4'h1, 12'd0, 14'($urandom_range(0, (1<<IMEM_AW)-1)), 2'($urandom_range(0, 3))};
    return $urandom();
  endfunction

  initial begin
    int k, st;
    logic [1:0] sel;
    for (int i = 0; i < (1<<BIOS_AW); i++) bios_mem[i] = $urandom();
    for (int i = 0; i < (1<<IMEM_AW); i++) imem_mem[i] = $urandom();
    rst = 1'b1; bus.stall = 1'b0; bus.pc_sel = 2'd0; bus.br_target = 32'h0;
    m_pc = RESET_PC; m_started = 1'b0; m_fault = 1'b0;

    // reset, free run from BIOS, redirect into IMEM at 0x4000_0008
    step(1'b1, 1'b0, 2'd0, 32'h0);
    step(1'b1, 1'b0, 2'd0, 32'h0);
    idle(3);
    step(1'b0, 1'b0, 2'd1, 32'h1000_0010);
    idle(2);
    // stall three cycles, then stall+redirect (stall wins), then redirect alone
    step(1'b0, 1'b1, 2'd0, 32'h0);
    step(1'b0, 1'b1, 2'd0, 32'h0);
    step(1'b0, 1'b1, 2'd0, 32'h0);
    idle(1);
    step(1'b0, 1'b1, 2'd1, 32'h4000_0100);
    step(1'b0, 1'b0, 2'd1, 32'h4000_0100);
    idle(1);
    // pc_sel=2 hold, pc_sel=3 as +4, misaligned target
    step(1'b0, 1'b0, 2'd2, 32'h0);
    step(1'b0, 1'b0, 2'd3, 32'h0);
    step(1'b0, 1'b0, 2'd1, 32'h1000_0013);
    idle(1);
    // invalid region -> sticky fault; wrap past 0xFFFF_FFFC
    step(1'b0, 1'b0, 2'd1, 32'h2000_0000);
    idle(4);
    step(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFC);
    idle(3);
    step(1'b0, 1'b0, 2'd1, 32'h1000_0000);
    idle(2);
    // reset during stall + redirect
    step(1'b1, 1'b1, 2'd1, 32'h1000_0040);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      k  = $urandom_range(0, 99);
      st = ($urandom_range(0, 99) < 15) ? 1 : 0;
      if      (k < 60) sel = 2'd0;
      else if (k < 82) sel = 2'd1;
      else if (k < 94) sel = 2'd2;
      else             sel = 2'd3;
      step(($urandom_range(0, 199) == 0), st[0], sel, rand_target());
    end

    step(1'b0, 1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
